// File: rtl/timetag_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the time-tag frame streamer.
package timetag_pkg;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int DROP_CNT_W   = 8;
  localparam int DROP_TOTAL_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_TRL  = 3'd4
  } state_e;

  function automatic int ceil_div8(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/timetag_sync_fifo.sv
// Single-clock record FIFO with registered read data; o_data updates on the cycle after a pop.
module timetag_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == {LVL_W{1'b0}});
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_rd_data;
  assign o_level   = r_level;

  // Record storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_level   <= {LVL_W{1'b0}};
      r_rd_data <= {WIDTH{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/timetag_frame_streamer.sv
// Buffers tagger records and streams each one as header, LSB-first payload and drop-count trailer
// over a registered valid/ready byte interface.
module timetag_frame_streamer
  import timetag_pkg::*;
#(
  parameter int         REC_WIDTH   = 143,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
  localparam int        NBYTES      = ceil_div8(REC_WIDTH),
  localparam int        LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    activate,
  input  logic                    rec_valid,
  input  logic [REC_WIDTH-1:0]    rec_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_byte,
  output logic [LVL_W-1:0]        fifo_level,
  output logic [DROP_TOTAL_W-1:0] drop_total,
  output logic                    busy
);

  localparam int SH_W  = NBYTES * 8;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_e                  r_state;
  state_e                  w_state_nx;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nx;
  logic [SH_W-1:0]         r_shreg;
  logic [SH_W-1:0]         w_shreg_nx;
  logic                    r_out_valid;
  logic                    w_out_valid_nx;
  logic [7:0]              r_out_byte;
  logic [7:0]              w_out_byte_nx;
  logic                    r_busy;
  logic                    w_busy_nx;
  logic                    w_pop;
  logic                    w_xfer;
  logic                    w_trl_done;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [REC_WIDTH-1:0]    w_rd_data;
  logic [LVL_W-1:0]        w_fifo_level;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic [DROP_TOTAL_W-1:0] r_drop_total;

  assign w_push     = rec_valid & activate & ~w_full;
  assign w_drop     = rec_valid & activate & w_full;
  assign w_xfer     = r_out_valid & out_ready;
  assign w_trl_done = (r_state == ST_TRL) & w_xfer;

  timetag_sync_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (rec_data),
    .i_pop   (w_pop),
    .o_data  (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_fifo_level)
  );

  // Framing FSM: each handshake loads the following byte directly, so bytes can go back-to-back.
  always_comb begin
    w_state_nx     = r_state;
    w_idx_nx       = r_idx;
    w_shreg_nx     = r_shreg;
    w_out_valid_nx = r_out_valid;
    w_out_byte_nx  = r_out_byte;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (activate) begin
          w_state_nx = ST_WAIT;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!activate) begin
          w_state_nx = ST_IDLE;
        end else if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = ST_HDR;
        end else begin
          w_state_nx = ST_WAIT;
        end
      end
      ST_HDR: begin
        // The popped record becomes readable on entry to HDR, so capture it with the header.
        if (!r_out_valid) begin
          w_out_valid_nx = 1'b1;
          w_out_byte_nx  = HEADER_BYTE;
          w_shreg_nx     = SH_W'(w_rd_data);
        end else if (out_ready) begin
          w_out_byte_nx = r_shreg[7:0];
          w_shreg_nx    = r_shreg >> 4'd8;
          w_idx_nx      = {IDX_W{1'b0}};
          w_state_nx    = ST_DATA;
        end else begin
          w_state_nx = ST_HDR;
        end
      end
      ST_DATA: begin
        if (w_xfer) begin
          if (r_idx == IDX_LAST) begin
            w_out_byte_nx = r_drop_cnt;
            w_state_nx    = ST_TRL;
          end else begin
            w_out_byte_nx = r_shreg[7:0];
            w_shreg_nx    = r_shreg >> 4'd8;
            w_idx_nx      = r_idx + IDX_W'(1);
          end
        end else begin
          w_state_nx = ST_DATA;
        end
      end
      ST_TRL: begin
        if (w_xfer) begin
          w_out_valid_nx = 1'b0;
          w_out_byte_nx  = 8'h00;
          if (activate) begin
            w_state_nx = ST_WAIT;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_state_nx = ST_TRL;
        end
      end
      default: begin
        w_state_nx     = ST_IDLE;
        w_out_valid_nx = 1'b0;
        w_out_byte_nx  = 8'h00;
      end
    endcase
    w_busy_nx = (w_state_nx == ST_HDR) || (w_state_nx == ST_DATA) || (w_state_nx == ST_TRL);
  end

  // FSM state, byte shifter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= {IDX_W{1'b0}};
      r_shreg     <= {SH_W{1'b0}};
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_shreg     <= w_shreg_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_byte  <= w_out_byte_nx;
      r_busy      <= w_busy_nx;
    end
  end

  // Per-frame drop count restarts on the trailer handshake, keeping a drop from that same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= {DROP_CNT_W{1'b0}};
    end else if (w_trl_done) begin
      r_drop_cnt <= w_drop ? DROP_CNT_W'(1) : {DROP_CNT_W{1'b0}};
    end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  // Lifetime drop total, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_total <= {DROP_TOTAL_W{1'b0}};
    end else if (w_drop && (r_drop_total != {DROP_TOTAL_W{1'b1}})) begin
      r_drop_total <= r_drop_total + DROP_TOTAL_W'(1);
    end else begin
      r_drop_total <= r_drop_total;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_byte   = r_out_byte;
  assign fifo_level = w_fifo_level;
  assign drop_total = r_drop_total;
  assign busy       = r_busy;

endmodule

// File: tb/tb_timetag_frame_streamer.sv
// Scoreboard bench for timetag_frame_streamer: expected frame bytes are queued as records are sent
// and compared on every observed byte handshake.
module tb_timetag_frame_streamer;

  localparam int RW    = 143;
  localparam int NB    = 18;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          activate;
  logic          rec_valid;
  logic [RW-1:0] rec_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic [2:0]    fifo_level;
  logic [15:0]   drop_total;
  logic          busy;

  int         checks = 0;
  int         errors = 0;
  int         xfer_count = 0;
  int         busy_xfers = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  timetag_frame_streamer #(
    .REC_WIDTH  (RW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .activate   (activate),
    .rec_valid  (rec_valid),
    .rec_data   (rec_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .fifo_level (fifo_level),
    .drop_total (drop_total),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rand_rec();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[RW-1:0];
  endfunction

  task automatic push_frame(input logic [RW-1:0] rec, input logic [7:0] trl);
    logic [NB*8-1:0] ext;
    ext = '0;
    ext[RW-1:0] = rec;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NB; i++) exp_q.push_back(ext[8*i +: 8]);
    exp_q.push_back(trl);
  endtask

  // One clock: observe the handshake at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_byte !== prev_byte) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b byte=%02h, required valid=1 byte=%02h", out_valid, out_byte, prev_byte);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        xfer_count++;
        if (busy === 1'b1) busy_xfers++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, required no byte", out_byte);
        end else begin
          e = exp_q.pop_front();
          if (out_byte !== e) begin
            errors++;
            $display("FAIL frame_byte: transfer %0d got %02h, required %02h", xfer_count, out_byte, e);
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_byte  = out_byte;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_rec(input logic [RW-1:0] r);
    rec_valid = 1'b1;
    rec_data  = r;
    cycle();
    rec_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    activate  = 1'b0;
    rec_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) break;
      cycle();
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: %0d bytes outstanding busy=%0b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b, required 0", out_valid); end
    if (out_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %02h, required 00", out_byte); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
    if (drop_total !== 16'd0) begin errors++; $display("FAIL rst_drops: got %0d, required 0", drop_total); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_single_frame();
    logic [RW-1:0] r;
    int x0;
    r = 143'h7F_0123456789ABCDEF_FEDCBA9876543210_55;
    do_reset();
    activate  = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();
    busy_xfers = 0;
    x0 = xfer_count;
    push_frame(r, 8'h00);
    send_rec(r);
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid=%0b at t+2, required 0", out_valid); end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin
      errors++;
      $display("FAIL latency_hdr: valid=%0b byte=%02h at t+3, required 1 and a5", out_valid, out_byte);
    end
    wait_drain(100);
    checks += 3;
    if (xfer_count - x0 != 20) begin errors++; $display("FAIL frame_len: got %0d, required 20", xfer_count - x0); end
    if (busy_xfers != 20) begin errors++; $display("FAIL busy_xfers: got %0d, required 20", busy_xfers); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL t1_level: got %0d, required 0", fifo_level); end
  endtask

  task automatic test_overflow();
    logic [RW-1:0] r;
    do_reset();
    activate = 1'b1;
    cycle();
    // First record goes straight into the framer, four fill the FIFO, the last two are dropped.
    for (int i = 0; i < 7; i++) begin
      r = rand_rec();
      if (i == 0) push_frame(r, 8'h02);
      else if (i < 5) push_frame(r, 8'h00);
      send_rec(r);
    end
    cycle();
    checks += 2;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d, required 4", fifo_level); end
    if (drop_total !== 16'd2) begin errors++; $display("FAIL ovf_drops: got %0d, required 2", drop_total); end
    out_ready = 1'b1;
    wait_drain(300);
  endtask

  task automatic test_random_ready();
    logic [RW-1:0] r;
    do_reset();
    activate = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      r = rand_rec();
      push_frame(r, 8'h00);
      send_rec(r);
    end
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) break;
      out_ready = ($urandom_range(0, 9) < 3);
      cycle();
    end
    out_ready = 1'b1;
    wait_drain(10);
  endtask

  task automatic test_deactivate();
    logic [RW-1:0] r;
    int x0;
    int x1;
    logic hit;
    do_reset();
    activate = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      r = rand_rec();
      push_frame(r, 8'h00);
      send_rec(r);
    end
    cycle();
    x0 = xfer_count;
    hit = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (xfer_count - x0 == 6) begin hit = 1'b1; break; end
      cycle();
    end
    activate = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0 && xfer_count - x0 >= 20) break;
      cycle();
    end
    repeat (3) cycle();
    checks += 4;
    if (!hit) begin errors++; $display("FAIL deact_trigger: byte 5 not reached, required reached"); end
    if (xfer_count - x0 != 20) begin errors++; $display("FAIL deact_frame: got %0d bytes, required 20", xfer_count - x0); end
    if (fifo_level !== 3'd2) begin errors++; $display("FAIL deact_level: got %0d, required 2", fifo_level); end
    if (exp_q.size() != 40) begin errors++; $display("FAIL deact_pending: got %0d, required 40", exp_q.size()); end
    send_rec(rand_rec());
    x1 = xfer_count;
    repeat (10) cycle();
    checks += 3;
    if (fifo_level !== 3'd2) begin errors++; $display("FAIL inactive_rec_level: got %0d, required 2", fifo_level); end
    if (drop_total !== 16'd0) begin errors++; $display("FAIL inactive_rec_drops: got %0d, required 0", drop_total); end
    if (xfer_count != x1) begin errors++; $display("FAIL idle_bytes: got %0d, required 0", xfer_count - x1); end
    activate = 1'b1;
    wait_drain(200);
  endtask

  task automatic test_drop_trailer();
    logic [RW-1:0] r;
    int x0;
    logic hit;
    do_reset();
    activate = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      r = rand_rec();
      push_frame(r, (i == 1) ? 8'h01 : 8'h00);
      send_rec(r);
    end
    x0 = xfer_count;
    hit = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (xfer_count - x0 == 19 && out_valid === 1'b1) begin
        rec_valid = 1'b1;
        rec_data  = rand_rec();
        cycle();
        rec_valid = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    wait_drain(300);
    checks += 2;
    if (!hit) begin errors++; $display("FAIL coincident_trigger: trailer not reached, required reached"); end
    if (drop_total !== 16'd1) begin errors++; $display("FAIL coincident_drops: got %0d, required 1", drop_total); end

    do_reset();
    activate = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      r = rand_rec();
      push_frame(r, (i == 0) ? 8'hFF : 8'h00);
      send_rec(r);
    end
    rec_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rec_data = rand_rec();
      cycle();
    end
    rec_valid = 1'b0;
    cycle();
    checks += 2;
    if (drop_total !== 16'd300) begin errors++; $display("FAIL sat_drops: got %0d, required 300", drop_total); end
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL sat_level: got %0d, required 4", fifo_level); end
    out_ready = 1'b1;
    wait_drain(300);
  endtask

  task automatic test_reset_mid_frame();
    logic [RW-1:0] r;
    int x0;
    int x1;
    logic hit;
    do_reset();
    activate = 1'b1;
    cycle();
    for (int i = 0; i < 7; i++) begin
      r = rand_rec();
      if (i < 5) push_frame(r, (i == 0) ? 8'h02 : 8'h00);
      send_rec(r);
    end
    checks++;
    if (drop_total !== 16'd2) begin errors++; $display("FAIL pre_reset_drops: got %0d, required 2", drop_total); end
    x0 = xfer_count;
    hit = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (xfer_count - x0 == 8) begin hit = 1'b1; break; end
      cycle();
    end
    reset = 1'b1;
    exp_q.delete();
    cycle();
    reset = 1'b0;
    checks += 5;
    if (!hit) begin errors++; $display("FAIL mid_trigger: idx 7 not reached, required reached"); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b, required 0", out_valid); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level: got %0d, required 0", fifo_level); end
    if (drop_total !== 16'd0) begin errors++; $display("FAIL mid_rst_drops: got %0d, required 0", drop_total); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b, required 0", busy); end
    x1 = xfer_count;
    repeat (30) cycle();
    checks++;
    if (xfer_count != x1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_quiet: got %0d bytes valid=%0b, required 0 and 0", xfer_count - x1, out_valid);
    end
    r = rand_rec();
    push_frame(r, 8'h00);
    send_rec(r);
    wait_drain(100);
  endtask

  initial begin
    reset     = 1'b1;
    activate  = 1'b0;
    rec_valid = 1'b0;
    rec_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_random_ready();
    test_deactivate();
    test_drop_trailer();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
